// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control
//
// Main decoder for a single-cycle MIPS-subset datapath. The instruction
// opcode/funct, the interrupt request and the kernel-mode bit are decoded
// combinationally. The resulting control word is registered, so every output
// follows its inputs by one clk cycle.
//
// Ports
//   clk       in   1  clock; outputs update on its rising edge
//   reset     in   1  asynchronous active-low reset; clears every output
//   Instruct  in  32  instruction word (op = [31:26], funct = [5:0])
//   IRQ       in   1  external interrupt request
//   PC31      in   1  PC bit 31; 1 = kernel mode (IRQ and traps masked)
//   PCSrc     out  3  next-PC select: 0 PC+4, 1 branch, 2 jump, 3 register,
//                     4 interrupt vector, 5 exception vector
//   RegDst    out  2  write register: 0 rd, 1 rt, 2 $31, 3 $k0
//   RegWr     out  1  register-file write enable
//   ALUSrc1   out  1  ALU A: 1 shamt, 0 rs
//   ALUSrc2   out  1  ALU B: 1 immediate, 0 rt
//   ALUFun    out  6  ALU operation code
//   Sign      out  1  signed arithmetic / compare
//   MemWr     out  1  data-memory write enable
//   MemRd     out  1  data-memory read enable
//   MemToReg  out  2  writeback: 0 ALU, 1 memory, 2 PC+4
//   ExtOp     out  1  immediate extension: 1 sign, 0 zero
//   LUOp      out  1  1 selects imm << 16 (lui)
// -----------------------------------------------------------------------------
module control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruct,
  input  logic        IRQ,
  input  logic        PC31,
  output logic [2:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        RegWr,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic        MemWr,
  output logic        MemRd,
  output logic [1:0]  MemToReg,
  output logic        ExtOp,
  output logic        LUOp
);

  // ALU operation codes
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // Field encodings
  localparam logic [2:0] PC_NEXT = 3'b000;
  localparam logic [2:0] PC_BR   = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  localparam logic [2:0] PC_REG  = 3'b011;
  localparam logic [2:0] PC_IRQ  = 3'b100;
  localparam logic [2:0] PC_EXC  = 3'b101;

  localparam logic [1:0] RD_RD = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] RD_K0 = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] pc_src;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       alu_src1;
    logic       alu_src2;
    logic [5:0] alu_fun;
    logic       sign;
    logic       mem_wr;
    logic       mem_rd;
    logic [1:0] mem_to_reg;
    logic       ext_op;
    logic       lu_op;
  } ctrl_t;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_legal;
  ctrl_t      w_dec;
  ctrl_t      w_next;
  ctrl_t      w_trap;
  ctrl_t      r_ctrl;
  logic       w_unused;

  assign w_op    = Instruct[31:26];
  assign w_funct = Instruct[5:0];

  // Register fields and immediates are consumed by the datapath, not here.
  assign w_unused = ^Instruct[25:6];

  // Instruction decode; w_legal drops for anything outside the supported set.
  always_comb begin
    w_dec   = '0;
    w_legal = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        w_dec.reg_dst = RD_RD;
        w_dec.reg_wr  = 1'b1;
        case (w_funct)
          FN_ADD:  begin w_dec.alu_fun = ALU_ADD; w_dec.sign = 1'b1; end
          FN_ADDU: w_dec.alu_fun = ALU_ADD;
          FN_SUB:  begin w_dec.alu_fun = ALU_SUB; w_dec.sign = 1'b1; end
          FN_SUBU: w_dec.alu_fun = ALU_SUB;
          FN_AND:  w_dec.alu_fun = ALU_AND;
          FN_OR:   w_dec.alu_fun = ALU_OR;
          FN_XOR:  w_dec.alu_fun = ALU_XOR;
          FN_NOR:  w_dec.alu_fun = ALU_NOR;
          FN_SLT:  begin w_dec.alu_fun = ALU_LT; w_dec.sign = 1'b1; end
          FN_SLL:  begin w_dec.alu_fun = ALU_SLL; w_dec.alu_src1 = 1'b1; end
          FN_SRL:  begin w_dec.alu_fun = ALU_SRL; w_dec.alu_src1 = 1'b1; end
          FN_SRA:  begin w_dec.alu_fun = ALU_SRA; w_dec.alu_src1 = 1'b1; end
          FN_JR: begin
            w_dec.pc_src = PC_REG;
            w_dec.reg_wr = 1'b0;
          end
          FN_JALR: begin
            w_dec.pc_src     = PC_REG;
            w_dec.mem_to_reg = WB_PC4;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_LW: begin
        w_dec.reg_dst    = RD_RT;
        w_dec.reg_wr     = 1'b1;
        w_dec.alu_src2   = 1'b1;
        w_dec.alu_fun    = ALU_ADD;
        w_dec.mem_rd     = 1'b1;
        w_dec.mem_to_reg = WB_MEM;
        w_dec.ext_op     = 1'b1;
        w_dec.sign       = 1'b1;
      end
      OP_SW: begin
        w_dec.alu_src2 = 1'b1;
        w_dec.alu_fun  = ALU_ADD;
        w_dec.mem_wr   = 1'b1;
        w_dec.ext_op   = 1'b1;
        w_dec.sign     = 1'b1;
      end
      // lui is executed as $0 + (imm << 16).
      OP_LUI: begin
        w_dec.reg_dst  = RD_RT;
        w_dec.reg_wr   = 1'b1;
        w_dec.alu_src2 = 1'b1;
        w_dec.lu_op    = 1'b1;
        w_dec.alu_fun  = ALU_ADD;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: begin
        w_dec.reg_dst  = RD_RT;
        w_dec.reg_wr   = 1'b1;
        w_dec.alu_src2 = 1'b1;
        case (w_op)
          OP_ADDI:  begin w_dec.alu_fun = ALU_ADD; w_dec.ext_op = 1'b1; w_dec.sign = 1'b1; end
          OP_ADDIU: begin w_dec.alu_fun = ALU_ADD; w_dec.ext_op = 1'b1; end
          OP_SLTI:  begin w_dec.alu_fun = ALU_LT;  w_dec.ext_op = 1'b1; w_dec.sign = 1'b1; end
          OP_SLTIU: begin w_dec.alu_fun = ALU_LT;  w_dec.ext_op = 1'b1; end
          default:  w_dec.alu_fun = ALU_AND;
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: begin
        w_dec.pc_src = PC_BR;
        w_dec.ext_op = 1'b1;
        w_dec.sign   = 1'b1;
        case (w_op)
          OP_BEQ:  w_dec.alu_fun = ALU_EQ;
          OP_BNE:  w_dec.alu_fun = ALU_NEQ;
          OP_BLEZ: w_dec.alu_fun = ALU_LEZ;
          OP_BGTZ: w_dec.alu_fun = ALU_GTZ;
          default: w_dec.alu_fun = ALU_LTZ;
        endcase
      end
      OP_J: w_dec.pc_src = PC_JMP;
      OP_JAL: begin
        w_dec.pc_src     = PC_JMP;
        w_dec.reg_dst    = RD_RA;
        w_dec.reg_wr     = 1'b1;
        w_dec.mem_to_reg = WB_PC4;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Trap entry saves PC+4 into $k0; the vector is chosen below.
  always_comb begin
    w_trap            = '0;
    w_trap.reg_dst    = RD_K0;
    w_trap.reg_wr     = 1'b1;
    w_trap.mem_to_reg = WB_PC4;
  end

  // Interrupts beat exceptions; kernel mode masks both, and an illegal
  // instruction in kernel mode degrades to a no-op.
  always_comb begin
    w_next = w_dec;
    if (!PC31 && IRQ) begin
      w_next        = w_trap;
      w_next.pc_src = PC_IRQ;
    end else if (!w_legal) begin
      if (PC31) begin
        w_next = '0;
      end else begin
        w_next        = w_trap;
        w_next.pc_src = PC_EXC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl <= w_next;
    end
  end

  assign PCSrc    = r_ctrl.pc_src;
  assign RegDst   = r_ctrl.reg_dst;
  assign RegWr    = r_ctrl.reg_wr;
  assign ALUSrc1  = r_ctrl.alu_src1;
  assign ALUSrc2  = r_ctrl.alu_src2;
  assign ALUFun   = r_ctrl.alu_fun;
  assign Sign     = r_ctrl.sign;
  assign MemWr    = r_ctrl.mem_wr;
  assign MemRd    = r_ctrl.mem_rd;
  assign MemToReg = r_ctrl.mem_to_reg;
  assign ExtOp    = r_ctrl.ext_op;
  assign LUOp     = r_ctrl.lu_op;

  // PC_NEXT / WB_ALU are the all-zero defaults and only appear implicitly.
  localparam logic [2:0] PC_NEXT_UNUSED = PC_NEXT;
  localparam logic [1:0] WB_ALU_UNUSED  = WB_ALU;

endmodule

// File: tb/tb_control.sv
module tb_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instruct = '0;
  logic        IRQ = 1'b0;
  logic        PC31 = 1'b0;
  logic [2:0]  PCSrc;
  logic [1:0]  RegDst;
  logic        RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, ExtOp, LUOp;
  logic [5:0]  ALUFun;
  logic [1:0]  MemToReg;

  control dut (
    .clk(clk), .reset(reset), .Instruct(Instruct), .IRQ(IRQ), .PC31(PC31),
    .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .ALUFun(ALUFun), .Sign(Sign), .MemWr(MemWr),
    .MemRd(MemRd), .MemToReg(MemToReg), .ExtOp(ExtOp), .LUOp(LUOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pcsrc;
    logic [1:0] regdst;
    logic       regwr;
    logic       a1;
    logic       a2;
    logic [5:0] fun;
    logic       sign;
    logic       mw;
    logic       mr;
    logic [1:0] m2r;
    logic       ext;
    logic       lu;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         rtype;
    out_t       o;
  } rule_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        irq;
    logic        pc31;
    out_t        exp;
  } vec_t;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b011000,
                         OR  = 6'b011110, XOR = 6'b010110, NOR = 6'b010001,
                         SLL = 6'b100000, SRL = 6'b100001, SRA = 6'b100011,
                         EQ  = 6'b110011, NEQ = 6'b110001, LT  = 6'b110101,
                         LEZ = 6'b111101, LTZ = 6'b111011, GTZ = 6'b111111;

  int tests = 0;
  int failed = 0;
  rule_t rules[$];
  vec_t  vecs[$];

  function automatic out_t mk(input logic [2:0] pc, input logic [1:0] rd,
                              input logic rw, input logic a1, input logic a2,
                              input logic [5:0] fn, input logic sg, input logic mw,
                              input logic mr, input logic [1:0] m2, input logic ex,
                              input logic lu);
    return out_t'({pc, rd, rw, a1, a2, fn, sg, mw, mr, m2, ex, lu});
  endfunction

  function automatic out_t irq_out();
    return mk(3'd4, 2'd3, 1, 0, 0, 6'd0, 0, 0, 0, 2'd2, 0, 0);
  endfunction

  function automatic out_t exc_out();
    return mk(3'd5, 2'd3, 1, 0, 0, 6'd0, 0, 0, 0, 2'd2, 0, 0);
  endfunction

  task automatic add_rule(input logic [5:0] op, input logic [5:0] fn, input bit rt, input out_t o);
    rule_t r;
    r.op = op; r.fn = fn; r.rtype = rt; r.o = o;
    rules.push_back(r);
  endtask

  task automatic add_vec(input string n, input logic [31:0] i, input logic q,
                         input logic k, input out_t e);
    vec_t v;
    v.name = n; v.instr = i; v.irq = q; v.pc31 = k; v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference: priority of IRQ, then look the instruction up in the rule table.
  function automatic out_t model(input logic [31:0] instr, input logic irq, input logic pc31);
    if (irq && !pc31) return irq_out();
    foreach (rules[i]) begin
      if (rules[i].op == instr[31:26] && (!rules[i].rtype || rules[i].fn == instr[5:0]))
        return rules[i].o;
    end
    return pc31 ? out_t'('0) : exc_out();
  endfunction

  function automatic out_t actual();
    return out_t'({PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, ALUFun, Sign,
                   MemWr, MemRd, MemToReg, ExtOp, LUOp});
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = actual();
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic q, input logic k);
    Instruct = i; IRQ = q; PC31 = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rule table built from the instruction list.
    add_rule(6'h23, 6'h00, 0, mk(0, 1, 1, 0, 1, ADD, 1, 0, 1, 1, 1, 0)); // lw
    add_rule(6'h2b, 6'h00, 0, mk(0, 0, 0, 0, 1, ADD, 1, 1, 0, 0, 1, 0)); // sw
    add_rule(6'h0f, 6'h00, 0, mk(0, 1, 1, 0, 1, ADD, 0, 0, 0, 0, 0, 1)); // lui
    add_rule(6'h00, 6'h20, 1, mk(0, 0, 1, 0, 0, ADD, 1, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h21, 1, mk(0, 0, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h22, 1, mk(0, 0, 1, 0, 0, SUB, 1, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h23, 1, mk(0, 0, 1, 0, 0, SUB, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h24, 1, mk(0, 0, 1, 0, 0, AND, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h25, 1, mk(0, 0, 1, 0, 0, OR,  0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h26, 1, mk(0, 0, 1, 0, 0, XOR, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h27, 1, mk(0, 0, 1, 0, 0, NOR, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h2a, 1, mk(0, 0, 1, 0, 0, LT,  1, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h00, 1, mk(0, 0, 1, 1, 0, SLL, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h02, 1, mk(0, 0, 1, 1, 0, SRL, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h03, 1, mk(0, 0, 1, 1, 0, SRA, 0, 0, 0, 0, 0, 0));
    add_rule(6'h00, 6'h08, 1, mk(3, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0)); // jr
    add_rule(6'h00, 6'h09, 1, mk(3, 0, 1, 0, 0, 6'd0, 0, 0, 0, 2, 0, 0)); // jalr
    add_rule(6'h08, 6'h00, 0, mk(0, 1, 1, 0, 1, ADD, 1, 0, 0, 0, 1, 0)); // addi
    add_rule(6'h09, 6'h00, 0, mk(0, 1, 1, 0, 1, ADD, 0, 0, 0, 0, 1, 0)); // addiu
    add_rule(6'h0c, 6'h00, 0, mk(0, 1, 1, 0, 1, AND, 0, 0, 0, 0, 0, 0)); // andi
    add_rule(6'h0a, 6'h00, 0, mk(0, 1, 1, 0, 1, LT,  1, 0, 0, 0, 1, 0)); // slti
    add_rule(6'h0b, 6'h00, 0, mk(0, 1, 1, 0, 1, LT,  0, 0, 0, 0, 1, 0)); // sltiu
    add_rule(6'h04, 6'h00, 0, mk(1, 0, 0, 0, 0, EQ,  1, 0, 0, 0, 1, 0));
    add_rule(6'h05, 6'h00, 0, mk(1, 0, 0, 0, 0, NEQ, 1, 0, 0, 0, 1, 0));
    add_rule(6'h06, 6'h00, 0, mk(1, 0, 0, 0, 0, LEZ, 1, 0, 0, 0, 1, 0));
    add_rule(6'h07, 6'h00, 0, mk(1, 0, 0, 0, 0, GTZ, 1, 0, 0, 0, 1, 0));
    add_rule(6'h01, 6'h00, 0, mk(1, 0, 0, 0, 0, LTZ, 1, 0, 0, 0, 1, 0));
    add_rule(6'h02, 6'h00, 0, mk(2, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0)); // j
    add_rule(6'h03, 6'h00, 0, mk(2, 2, 1, 0, 0, 6'd0, 0, 0, 0, 2, 0, 0)); // jal

    // Directed vectors with hand-written expectations.
    add_vec("lw",        32'h8fa40000, 0, 0, mk(0, 1, 1, 0, 1, 6'b000000, 1, 0, 1, 1, 1, 0));
    add_vec("jal",       32'h0c000003, 0, 0, mk(2, 2, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("jalr",      32'h0120f809, 0, 0, mk(3, 0, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("sra",       32'h000a4883, 0, 0, mk(0, 0, 1, 1, 0, 6'b100011, 0, 0, 0, 0, 0, 0));
    add_vec("sltiu",     32'h2d49ff9c, 0, 0, mk(0, 1, 1, 0, 1, 6'b110101, 0, 0, 0, 0, 1, 0));
    add_vec("exc",       32'hffffffff, 0, 0, mk(5, 3, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("irq_exc",   32'hffffffff, 1, 0, mk(4, 3, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("kern_ill",  32'hffffffff, 0, 1, 21'h0);
    add_vec("kern_irq",  32'hffffffff, 1, 1, 21'h0);
    add_vec("kern_add",  32'h00821020, 1, 1, mk(0, 0, 1, 0, 0, 6'b000000, 1, 0, 0, 0, 0, 0));
    add_vec("irq_add",   32'h00821020, 1, 0, mk(4, 3, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("sw",        32'hafbf0004, 0, 0, mk(0, 0, 0, 0, 1, 6'b000000, 1, 1, 0, 0, 1, 0));
    add_vec("irq_sw",    32'hafbf0004, 1, 0, mk(4, 3, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("lui",       32'h3c011234, 0, 0, mk(0, 1, 1, 0, 1, 6'b000000, 0, 0, 0, 0, 0, 1));
    add_vec("beq",       32'h10850003, 0, 0, mk(1, 0, 0, 0, 0, 6'b110011, 1, 0, 0, 0, 1, 0));
    add_vec("bltz",      32'h04a0fffe, 0, 0, mk(1, 0, 0, 0, 0, 6'b111011, 1, 0, 0, 0, 1, 0));
    add_vec("andi",      32'h30a5ffff, 0, 0, mk(0, 1, 1, 0, 1, 6'b011000, 0, 0, 0, 0, 0, 0));
    add_vec("jr",        32'h03e00008, 0, 0, mk(3, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
    add_vec("bad_funct", 32'h0000003f, 0, 0, mk(5, 3, 1, 0, 0, 6'b000000, 0, 0, 0, 2, 0, 0));
    add_vec("kern_badf", 32'h0000003f, 0, 1, 21'h0);
    add_vec("sll",       32'h00042080, 0, 0, mk(0, 0, 1, 1, 0, 6'b100000, 0, 0, 0, 0, 0, 0));
    add_vec("slt",       32'h0085102a, 0, 0, mk(0, 0, 1, 0, 0, 6'b110101, 1, 0, 0, 0, 0, 0));
    add_vec("j",         32'h08000010, 0, 0, mk(2, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0));

    // Reset state: asserted asynchronously before any clock edge.
    drive(32'h8fa40000, 0, 0);
    #1 reset = 1'b0;
    #1 check("reset_async", '0);
    step();
    check("reset_held", '0);
    reset = 1'b1;
    #1 check("reset_release_noedge", '0);
    step();
    check("reset_first_edge", model(32'h8fa40000, 0, 0));

    // Directed table.
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].irq, vecs[i].pc31);
      step();
      check(vecs[i].name, vecs[i].exp);
    end

    // One-cycle latency: new inputs must not show before the edge.
    drive(32'h8fa40000, 0, 0);
    step();
    drive(32'hffffffff, 0, 0);
    #2 check("latency_hold", model(32'h8fa40000, 0, 0));
    step();
    check("latency_update", exc_out());

    // Reset mid-sequence, away from any clock edge.
    drive(32'h0c000003, 0, 0);
    step();
    check("pre_reset_jal", model(32'h0c000003, 0, 0));
    #2 reset = 1'b0;
    #1 check("reset_mid_async", '0);
    step();
    check("reset_mid_held", '0);
    reset = 1'b1;
    #1 check("reset_mid_release", '0);
    step();
    check("reset_mid_reload", model(32'h0c000003, 0, 0));

    // Randomized instructions against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic        q, k;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        int r;
        r = $urandom_range(0, rules.size() - 1);
        ins[31:26] = rules[r].op;
        if (rules[r].rtype) ins[5:0] = rules[r].fn;
      end
      q = ($urandom_range(0, 4) == 0);
      k = ($urandom_range(0, 3) == 0);
      drive(ins, q, k);
      step();
      check($sformatf("rand_%0d_%08h_i%0d_k%0d", n, ins, q, k), model(ins, q, k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
